sata_tx_scheduler: RTL and testbench

Link-side transmit scheduler that owns the 32-bit PHY TX dword slot once the PHY reports ready. It arbitrates each cycle between:
- mandatory ALIGN-pair insertion on a fixed dword interval,
- a link-layer primitive requester,
- a frame-data requester,
- a SYNC idle filler.

It sits between the link layer and the PHY layer and drives the PHY's post-linkup tx_dout/tx_isk.

---
 rtl/sata_defines.sv | 26 ++
 rtl/sata_tx_align_timer.sv | 39 +++
 rtl/sata_tx_scheduler.sv | 163 ++++++++++++++++
 tb/tb_sata_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_defines.sv
// ---------------------------------------------------------------------------
// sata_defines
// Shared constants for the SATA link-side transmit path.
//   PRIM_ALIGN / PRIM_SYNC / PRIM_CONT : primitive dwords, K28.x in byte 0
//   sched_state_t                      : scheduler FSM encoding
//   lfsr_next()                        : scrambler step for CONT junk dwords
// ---------------------------------------------------------------------------
package sata_defines;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] PRIM_CONT  = 32'h9999_AA7C;

    typedef enum logic [1:0] {
        SCHED_OFF   = 2'd0,
        SCHED_ALIGN = 2'd1,
        SCHED_RUN   = 2'd2
    } sched_state_t;

    // One step of the x^32+x^22+x^2+x+1 Fibonacci LFSR, shifting left and
    // feeding the new bit in at bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/sata_tx_align_timer.sv
// ---------------------------------------------------------------------------
// sata_tx_align_timer
// Dword slot counter that paces ALIGN-pair insertion.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : count while high; counter is held at 0 while low
//   wrap      : current slot is the last of the interval (next slot is 0)
//   in_burst  : current slot is inside the ALIGN window and is not its
//               final slot, i.e. the burst continues into the next cycle
// ---------------------------------------------------------------------------
module sata_tx_align_timer #(
    parameter int ALIGN_INTERVAL = 256,
    parameter int ALIGN_BURST    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic wrap,
    output logic in_burst
);

    localparam int CW = $clog2(ALIGN_INTERVAL);
    localparam logic [CW-1:0] LAST_BURST_SLOT = CW'(ALIGN_BURST - 1);

    logic [CW-1:0] slot_cnt;

    // The interval is a power of two, so the natural rollover of the
    // counter is the wrap from ALIGN_INTERVAL-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    assign wrap     = enable && (slot_cnt == '1);
    assign in_burst = enable && (slot_cnt < LAST_BURST_SLOT);

endmodule

// File: rtl/sata_tx_scheduler.sv
// ---------------------------------------------------------------------------
// sata_tx_scheduler
// Owns the PHY TX dword slot once the PHY is ready. Each cycle it chooses,
// in priority order: ALIGN burst, link primitive, frame data, SYNC filler.
//   clk, rst            : clock, synchronous active-high reset
//   phy_ready           : PHY ready; scheduler idles in OFF while low
//   prim_req/prim_din   : primitive requester; prim_ack accepts (comb)
//   data_valid/data_din : data requester; data_ready accepts (comb)
//   tx_dout/tx_isk      : registered dword to the PHY (one cycle latency)
//   align_active        : registered, ALIGN currently on tx_dout
//   sched_state         : debug view of the FSM state
// Build option: define SATA_TX_SCHED_CONT_EN to enable repeated-primitive
// suppression (CONT followed by LFSR junk dwords).
// ---------------------------------------------------------------------------
module sata_tx_scheduler
    import sata_defines::*;
#(
    parameter int ALIGN_INTERVAL = 256,
    parameter int ALIGN_BURST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_ready,
    input  logic        prim_req,
    input  logic [31:0] prim_din,
    output logic        prim_ack,
    input  logic        data_valid,
    input  logic [31:0] data_din,
    output logic        data_ready,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    output logic        align_active,
    output logic [1:0]  sched_state
);

    sched_state_t state;
    logic         timer_en;
    logic         wrap;
    logic         in_burst;
    logic         grant_ok;
    logic [31:0]  prim_word;
    logic         prim_isk;

    assign timer_en = phy_ready && (state != SCHED_OFF);

    sata_tx_align_timer #(
        .ALIGN_INTERVAL(ALIGN_INTERVAL),
        .ALIGN_BURST   (ALIGN_BURST)
    ) u_align_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (timer_en),
        .wrap    (wrap),
        .in_burst(in_burst)
    );

    // Grants are gated by rst and phy_ready directly so that a reset or a
    // PHY drop kills the handshake in the very cycle it happens, before the
    // state register has had a chance to leave RUN.
    assign grant_ok    = !rst && phy_ready && (state == SCHED_RUN);
    assign prim_ack    = grant_ok && prim_req;
    assign data_ready  = grant_ok && !prim_req && data_valid;
    assign sched_state = state;

`ifdef SATA_TX_SCHED_CONT_EN
    logic [31:0] last_prim;
    logic [1:0]  rep_cnt;
    logic [31:0] lfsr;
    logic        same_prim;
    logic [1:0]  rep_next;

    // rep_cnt is the run length of identical accepted primitives so far,
    // saturating at 3. The third in a run becomes CONT; every later one is
    // replaced by a fresh scrambler dword sent as data.
    always_comb begin
        same_prim = (rep_cnt != 2'd0) && (prim_din == last_prim);
        rep_next  = 2'd1;
        prim_word = prim_din;
        prim_isk  = 1'b1;
        if (same_prim) begin
            rep_next = (rep_cnt == 2'd3) ? 2'd3 : rep_cnt + 2'd1;
            if (rep_cnt == 2'd2) begin
                prim_word = PRIM_CONT;
            end else if (rep_cnt == 2'd3) begin
                prim_word = lfsr_next(lfsr);
                prim_isk  = 1'b0;
            end
        end
    end

    // Any cycle that does not accept a primitive (data, filler, ALIGN, OFF)
    // breaks the run, so the next primitive always goes out literally.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_prim <= '0;
            rep_cnt   <= 2'd0;
            lfsr      <= 32'hFFFF_FFFF;
        end else if (prim_ack) begin
            last_prim <= prim_din;
            rep_cnt   <= rep_next;
            if (same_prim && (rep_cnt == 2'd3)) begin
                lfsr <= lfsr_next(lfsr);
            end
        end else begin
            rep_cnt <= 2'd0;
        end
    end
`else
    assign prim_word = prim_din;
    assign prim_isk  = 1'b1;
`endif

    // FSM and registered TX outputs share one block so the dword on tx_dout
    // always reflects the decision made in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst || !phy_ready) begin
            state        <= SCHED_OFF;
            tx_dout      <= PRIM_ALIGN;
            tx_isk       <= 1'b1;
            align_active <= 1'b1;
        end else begin
            case (state)
                SCHED_OFF: begin
                    state        <= SCHED_ALIGN;
                    tx_dout      <= PRIM_ALIGN;
                    tx_isk       <= 1'b1;
                    align_active <= 1'b1;
                end
                SCHED_ALIGN: begin
                    if (!in_burst) begin
                        state <= SCHED_RUN;
                    end
                    tx_dout      <= PRIM_ALIGN;
                    tx_isk       <= 1'b1;
                    align_active <= 1'b1;
                end
                SCHED_RUN: begin
                    if (wrap) begin
                        state <= SCHED_ALIGN;
                    end
                    align_active <= 1'b0;
                    if (prim_ack) begin
                        tx_dout <= prim_word;
                        tx_isk  <= prim_isk;
                    end else if (data_ready) begin
                        tx_dout <= data_din;
                        tx_isk  <= 1'b0;
                    end else begin
                        tx_dout <= PRIM_SYNC;
                        tx_isk  <= 1'b1;
                    end
                end
                default: begin
                    state        <= SCHED_OFF;
                    tx_dout      <= PRIM_ALIGN;
                    tx_isk       <= 1'b1;
                    align_active <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sata_tx_scheduler
// Scoreboard bench for sata_tx_scheduler. Requesters push the dword they
// expect to see on tx_dout when they present it; a negedge monitor pops and
// compares one cycle after every accept. Directed checks cover reset, ALIGN
// timing, gaps in held streams, the RUN->ALIGN boundary, PHY drop and reset.
// ---------------------------------------------------------------------------
module tb_sata_tx_scheduler;

    localparam logic [31:0] EXP_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] EXP_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] EXP_CONT  = 32'h9999_AA7C;
    localparam logic [31:0] X_RDY     = 32'h5757_B57C;
    localparam logic [31:0] R_RDY     = 32'h4A4A_957C;

    logic        clk = 1'b0;
    logic        rst;
    logic        phy_ready;
    logic        prim_req;
    logic [31:0] prim_din;
    logic        prim_ack;
    logic        data_valid;
    logic [31:0] data_din;
    logic        data_ready;
    logic [31:0] tx_dout;
    logic        tx_isk;
    logic        align_active;
    logic [1:0]  sched_state;

    sata_tx_scheduler #(
        .ALIGN_INTERVAL(256),
        .ALIGN_BURST   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phy_ready   (phy_ready),
        .prim_req    (prim_req),
        .prim_din    (prim_din),
        .prim_ack    (prim_ack),
        .data_valid  (data_valid),
        .data_din    (data_din),
        .data_ready  (data_ready),
        .tx_dout     (tx_dout),
        .tx_isk      (tx_isk),
        .align_active(align_active),
        .sched_state (sched_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dout;
        logic        isk;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] primInQ[$];
    exp_t        primExpQ[$];
    int          codes[$];
    int          dataLeft = 0;
    logic [31:0] dataWord = '0;
    int          checkCount = 0;
    int          errorCount = 0;
    logic        pendCheck = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ready, input logic preq,
                                 input logic [31:0] pdin, input logic dval,
                                 input logic [31:0] ddin);
        rst        = r;
        phy_ready  = ready;
        prim_req   = preq;
        prim_din   = pdin;
        data_valid = dval;
        data_din   = ddin;
    endtask

    // The accepted dword shows up on tx_dout one edge after the accept, so
    // the monitor remembers the accept and compares on the following negedge.
    always @(negedge clk) begin
        exp_t e;
        if (pendCheck) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL sb_unexpected_accept: got dout %h with no expected entry", tx_dout);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_dout", tx_dout, e.dout);
                checkOutput("sb_isk", {31'b0, tx_isk}, {31'b0, e.isk});
            end
        end
        pendCheck = prim_ack | data_ready;
    end

    task automatic addPrim(input logic [31:0] word, input logic [31:0] expDout, input logic expIsk);
        primInQ.push_back(word);
        primExpQ.push_back({expDout, expIsk});
    endtask

    task automatic startPrim();
        if (primInQ.size() > 0) begin
            prim_din = primInQ[0];
            prim_req = 1'b1;
            expQ.push_back(primExpQ[0]);
        end
    endtask

    task automatic startData(input logic [31:0] first, input int n);
        dataWord   = first;
        dataLeft   = n;
        data_din   = first;
        data_valid = 1'b1;
        expQ.push_back({first, 1'b0});
    endtask

    // One clock: sample the handshake mid-cycle, then advance the requesters
    // just after the edge as a real holding requester would.
    task automatic stepCycle(output logic pa, output logic da);
        @(negedge clk);
        pa = prim_ack;
        da = data_ready;
        @(posedge clk);
        #1;
        if (pa && primInQ.size() > 0) begin
            primInQ.delete(0);
            primExpQ.delete(0);
            if (primInQ.size() > 0) begin
                prim_din = primInQ[0];
                expQ.push_back(primExpQ[0]);
            end else begin
                prim_req = 1'b0;
            end
        end
        if (da && dataLeft > 0) begin
            dataLeft--;
            dataWord = dataWord + 32'd1;
            if (dataLeft > 0) begin
                data_din = dataWord;
                expQ.push_back({dataWord, 1'b0});
            end else begin
                data_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input int n);
        logic pa, da;
        repeat (n) stepCycle(pa, da);
    endtask

    task automatic runStreams(input int budget, output int used);
        logic pa, da;
        codes.delete();
        used = 0;
        while ((prim_req || data_valid) && used < budget) begin
            stepCycle(pa, da);
            codes.push_back(2 * int'(pa) + int'(da));
            used++;
        end
        if (prim_req || data_valid) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL stream_timeout: still pending after %0d cycles, required completion", used);
        end
    endtask

    task automatic checkGaps(input string name, input int expFirst, input int expCount);
        int first = -1;
        int cnt   = 0;
        foreach (codes[i]) begin
            if (codes[i] == 0) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        checkOutput({name, "_gap_count"}, cnt, expCount);
        checkOutput({name, "_first_gap"}, first, expFirst);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic pa, da;
        int   used;
        int   bexp[4];

        // Reset with both requesters asserted: nothing may be accepted.
        applyStimulus(1'b1, 1'b0, 1'b1, X_RDY, 1'b1, 32'h0000_1234);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {30'b0, sched_state}, 32'd0);
        checkOutput("reset_dout", tx_dout, EXP_ALIGN);
        checkOutput("reset_isk", {31'b0, tx_isk}, 32'd1);
        checkOutput("reset_align_active", {31'b0, align_active}, 32'd1);
        checkOutput("reset_prim_ack", {31'b0, prim_ack}, 32'd0);
        checkOutput("reset_data_ready", {31'b0, data_ready}, 32'd0);

        // PHY ready, no requests: ALIGN pair, then SYNC; next pair 256 later.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1);
        checkOutput("up_state_align", {30'b0, sched_state}, 32'd1);
        tick(1);
        checkOutput("up_align0", tx_dout, EXP_ALIGN);
        tick(1);
        checkOutput("up_state_run", {30'b0, sched_state}, 32'd2);
        checkOutput("up_align1", tx_dout, EXP_ALIGN);
        tick(1);
        checkOutput("up_sync", tx_dout, EXP_SYNC);
        checkOutput("up_sync_isk", {31'b0, tx_isk}, 32'd1);
        checkOutput("up_sync_not_align", {31'b0, align_active}, 32'd0);
        tick(253);
        checkOutput("pre_wrap_sync", tx_dout, EXP_SYNC);
        tick(1);
        checkOutput("wrap_align0", tx_dout, EXP_ALIGN);
        checkOutput("wrap_align_active", {31'b0, align_active}, 32'd1);
        tick(1);
        checkOutput("wrap_align1", tx_dout, EXP_ALIGN);
        tick(1);
        checkOutput("post_wrap_sync", tx_dout, EXP_SYNC);

        // Held primitive stream starting at slot 3: the only stalls are the
        // two ALIGN slots after the wrap, 253 cycles in.
        for (int i = 0; i < 259; i++) begin
`ifdef SATA_TX_SCHED_CONT_EN
            if (i % 2 == 0) addPrim(X_RDY, X_RDY, 1'b1);
            else            addPrim(R_RDY, R_RDY, 1'b1);
`else
            addPrim(X_RDY, X_RDY, 1'b1);
`endif
        end
        startPrim();
        runStreams(400, used);
        checkOutput("prim_cycles", used, 261);
        checkGaps("prim", 253, 2);

        // 300 incrementing data dwords from slot 8: 248 before the ALIGN pair.
        startData(32'd0, 300);
        runStreams(400, used);
        checkOutput("data_cycles", used, 302);
        checkGaps("data", 248, 2);

        // Both requesters appear as the FSM enters ALIGN (slot 0): two dead
        // cycles, then the primitive, then the data dword.
        tick(202);
        addPrim(R_RDY, R_RDY, 1'b1);
        startPrim();
        startData(32'hDEAD_BEEF, 1);
        runStreams(10, used);
        checkOutput("boundary_cycles", used, 4);
        bexp = '{0, 0, 2, 1};
        for (int i = 0; i < 4; i++) begin
            checkOutput("boundary_grant", (i < codes.size()) ? codes[i] : -1, bexp[i]);
        end

        // PHY drop in the middle of a data burst.
        startData(32'd100, 10);
        tick(3);
        phy_ready = 1'b0;
        stepCycle(pa, da);
        checkOutput("drop_ready0", {31'b0, da}, 32'd0);
        checkOutput("drop_dout", tx_dout, EXP_ALIGN);
        checkOutput("drop_state", {30'b0, sched_state}, 32'd0);
        stepCycle(pa, da);
        checkOutput("drop_ready1", {31'b0, da}, 32'd0);
        stepCycle(pa, da);
        checkOutput("drop_ready2", {31'b0, da}, 32'd0);
        phy_ready = 1'b1;
        runStreams(20, used);
        checkOutput("restore_cycles", used, 10);
        checkGaps("restore", 0, 3);

        // Reset while data is flowing: no accept in the reset cycle.
        startData(32'd200, 5);
        tick(2);
        rst = 1'b1;
        stepCycle(pa, da);
        checkOutput("midreset_data_ready", {31'b0, da}, 32'd0);
        checkOutput("midreset_prim_ack", {31'b0, pa}, 32'd0);
        checkOutput("midreset_state", {30'b0, sched_state}, 32'd0);
        checkOutput("midreset_dout", tx_dout, EXP_ALIGN);
        data_valid = 1'b0;
        dataLeft   = 0;
        if (expQ.size() > 0) expQ.delete(expQ.size() - 1);
        checkOutput("midreset_sb_empty", expQ.size(), 0);

        // Six identical primitives then a different one.
        rst = 1'b0;
        tick(3);
`ifdef SATA_TX_SCHED_CONT_EN
        addPrim(X_RDY, X_RDY, 1'b1);
        addPrim(X_RDY, X_RDY, 1'b1);
        addPrim(X_RDY, EXP_CONT, 1'b1);
        addPrim(X_RDY, 32'hFFFF_FFFE, 1'b0);
        addPrim(X_RDY, 32'hFFFF_FFFD, 1'b0);
        addPrim(X_RDY, 32'hFFFF_FFFB, 1'b0);
`else
        for (int i = 0; i < 6; i++) addPrim(X_RDY, X_RDY, 1'b1);
`endif
        addPrim(R_RDY, R_RDY, 1'b1);
        startPrim();
        runStreams(20, used);
        checkOutput("repeat_cycles", used, 7);

        tick(2);
        checkOutput("sb_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
